// File: rtl/arith_pkg.sv
// arith_pkg: definitions shared by the serial arithmetic cells.
//   state_t : controller state encoding (IDLE / SHIFT / DONE)
//   clog2   : width of a counter that must reach n-1 (never less than 1)
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_fs_cell.sv
// sync_fs_cell: 1-bit full subtractor with a registered borrow.
//   clk, rst  : clock, synchronous active-high reset (clears the borrow)
//   en        : advance the borrow to brw_nxt on this edge
//   clr       : seed the borrow to 0 (start of a new operation)
//   a0, b0    : current minuend / subtrahend bits
//   d         : difference bit for the current position (combinational)
//   brw_nxt   : borrow out of the current position (combinational)
module sync_fs_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic a0,
  input  logic b0,
  output logic d,
  output logic brw_nxt
);

  logic brw;

  always_comb begin
    d       = a0 ^ b0 ^ brw;
    brw_nxt = (~a0 & b0) | (~(a0 ^ b0) & brw);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      brw <= 1'b0;
    end else if (clr) begin
      brw <= 1'b0;
    end else if (en) begin
      brw <= brw_nxt;
    end
  end

endmodule

// File: rtl/sync_serial_sub.sv
// sync_serial_sub: bit-serial a - b, LSB first, one bit per clock.
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, honoured only while idle
//   a, b        : operands, captured on the accepting edge
//   busy        : operation in progress
//   done        : one-cycle pulse when results are valid
//   diff        : a - b mod 2^WIDTH
//   borrow_out  : unsigned a < b
//   overflow    : two's complement overflow of a - b
// All outputs are registered and change together on the edge entering DONE.
module sync_serial_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only WIDTH-1 result bits need storing: the last bit goes straight to diff.
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_cat;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;
  logic             cell_d;
  logic             cell_brw_nxt;
  logic             cell_en;
  logic             cell_clr;

  always_comb begin
    cell_en  = (state == ST_SHIFT);
    cell_clr = (state == ST_IDLE) && start;
    res_cat  = {cell_d, res_sr};
  end

  sync_fs_cell u_cell (
    .clk     (clk),
    .rst     (rst),
    .en      (cell_en),
    .clr     (cell_clr),
    .a0      (a_sr[0]),
    .b0      (b_sr[0]),
    .d       (cell_d),
    .brw_nxt (cell_brw_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= res_cat[WIDTH-1:1];
          if (cnt == CNT_LAST) begin
            // cell_d is the result MSB on this final bit.
            diff       <= res_cat;
            borrow_out <= cell_brw_nxt;
            overflow   <= (a_msb ^ b_msb) & (cell_d ^ a_msb);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_serial_sub.sv
// tb_sync_serial_sub: directed and random checks of sync_serial_sub (WIDTH=8)
// against an arithmetic reference model.
module tb_sync_serial_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int total;
  int bad;
  int done_seen;

  sync_serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction on the operands.
  task automatic model(input logic [W-1:0] va, input logic [W-1:0] vb,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int sa;
    int sb;
    int sd;
    int ud;
    sa = (int'(va) >= 128) ? int'(va) - 256 : int'(va);
    sb = (int'(vb) >= 128) ? int'(vb) - 256 : int'(vb);
    sd = sa - sb;
    ud = int'(va) - int'(vb);
    ed = W'((ud + 256) % 256);
    eb = (ud < 0);
    eo = (sd > 127) || (sd < -128);
  endtask

  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           n;
    model(va, vb, ed, eb, eo);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", 32'(n), 32'(W));
      chk("diff", 32'(diff), 32'(ed));
      chk("borrow_out", 32'(borrow_out), 32'(eb));
      chk("overflow", 32'(overflow), 32'(eo));
      chk("busy_in_done", 32'(busy), 32'd0);
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    int n;
    total = 0; bad = 0; done_seen = 0;
    rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    start = 1'b0;
    rst = 1'b0;

    do_op(8'h50, 8'h30);
    do_op(8'h30, 8'h50);
    do_op(8'h80, 8'h01);
    do_op(8'h7F, 8'hFF);
    do_op(8'h00, 8'h00);
    do_op(8'hFF, 8'hFF);
    do_op(8'h00, 8'h01);
    do_op(8'hFF, 8'h00);

    // Re-pulsed start during SHIFT and during DONE must be ignored.
    d0 = done_seen;
    @(negedge clk);
    a = 8'h50; b = 8'h30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ign_done_seen", 32'(done), 32'd1);
    a = 8'h33; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy_after_done", 32'(busy), 32'd0);
    chk("ign_done_low", 32'(done), 32'd0);
    chk("ign_diff", 32'(diff), 32'h20);
    repeat (W + 3) @(negedge clk);
    chk("ign_one_pulse", 32'(done_seen - d0), 32'd1);
    chk("ign_diff_hold", 32'(diff), 32'h20);
    chk("ign_still_idle", 32'(busy), 32'd0);

    // Reset in the middle of SHIFT aborts without a done pulse.
    d0 = done_seen;
    @(negedge clk);
    a = 8'h80; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow_out), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    repeat (W + 3) @(negedge clk);
    chk("abort_no_done", 32'(done_seen - d0), 32'd0);
    do_op(8'h30, 8'h50);

    for (int i = 0; i < 1000; i++) begin
      do_op(W'($urandom), W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
